// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver. Host writes land in a pending shadow and are
// committed only on the frame wrap, so a frame never shows a mix of old and new digits.
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int LZ_SUPPRESS    = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    upd_pending,
    output logic                    frame_tick
);
    localparam int DW = 4*NUM_DIGITS;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]         div_q;
    logic [IW-1:0]         idx_q;
    logic [DW-1:0]         disp_data_q, pend_data_q;
    logic [NUM_DIGITS-1:0] disp_dp_q, pend_dp_q, disp_blank_q, pend_blank_q;
    logic                  upd_q;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic                  frame_wrap, slot_wrap, guard, run, sup;
    logic [NUM_DIGITS-1:0] lz_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, cur_lz;
    logic [7:0]            seg_lit;
    logic [NUM_DIGITS-1:0] dig_lit;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: dec7 = 7'h3F; 4'h1: dec7 = 7'h06; 4'h2: dec7 = 7'h5B; 4'h3: dec7 = 7'h4F;
            4'h4: dec7 = 7'h66; 4'h5: dec7 = 7'h6D; 4'h6: dec7 = 7'h7D; 4'h7: dec7 = 7'h07;
            4'h8: dec7 = 7'h7F; 4'h9: dec7 = 7'h6F; 4'hA: dec7 = 7'h77; 4'hB: dec7 = 7'h7C;
            4'hC: dec7 = 7'h39; 4'hD: dec7 = 7'h5E; 4'hE: dec7 = 7'h79; default: dec7 = 7'h71;
        endcase
    endfunction

    assign slot_wrap  = (div_q == CW'(SCAN_DIV-1));
    assign frame_wrap = slot_wrap && (idx_q == IW'(NUM_DIGITS-1));
    assign guard      = (BLANK_CYCLES > 0) && (div_q < CW'(BLANK_CYCLES));

    always_comb begin
        // lz_zero[k]: every digit from k upward is zero or blanked, so k is a leading zero
        run       = 1'b1;
        lz_zero   = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_lz    = 1'b0;
        for (int k = NUM_DIGITS-1; k >= 0; k--) begin
            run        = run & ((disp_data_q[4*k +: 4] == 4'h0) | disp_blank_q[k]);
            lz_zero[k] = run;
            if (idx_q == IW'(k)) begin
                cur_nib   = disp_data_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = disp_blank_q[k];
                cur_lz    = run;
            end
        end
        sup     = (LZ_SUPPRESS != 0) && (idx_q != '0) && cur_lz;
        seg_lit = 8'h00;
        dig_lit = '0;
        if (!guard && !cur_blank) begin
            seg_lit = sup ? {cur_dp, 7'h00} : {cur_dp, dec7(cur_nib)};
            // a suppressed digit still lights its enable when it carries a decimal point
            if (!sup || cur_dp) dig_lit = NUM_DIGITS'(1) << idx_q;
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
        dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_lit : dig_lit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            upd_q        <= 1'b0;
            seg_q        <= (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
            dig_q        <= (DIG_ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            if (slot_wrap) begin
                div_q <= '0;
                idx_q <= frame_wrap ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (wr_en) begin
                pend_data_q  <= wr_data;
                pend_dp_q    <= wr_dp;
                pend_blank_q <= wr_blank;
            end
            if (frame_wrap) begin
                upd_q <= 1'b0;
                if (wr_en) begin
                    disp_data_q  <= wr_data;
                    disp_dp_q    <= wr_dp;
                    disp_blank_q <= wr_blank;
                end else if (upd_q) begin
                    disp_data_q  <= pend_data_q;
                    disp_dp_q    <= pend_dp_q;
                    disp_blank_q <= pend_blank_q;
                end
            end else if (wr_en) begin
                upd_q <= 1'b1;
            end
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg         = seg_q;
    assign dig         = dig_q;
    assign upd_pending = upd_q;
    assign frame_tick  = frame_wrap;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux: two instances (leading-zero suppression off/on)
// share stimulus and are checked every cycle against a time-indexed display model.
module tb_seg_scan_mux;
    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FR = N*SD;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en = 1'b0;
    logic [15:0]  wr_data = '0;
    logic [3:0]   wr_dp = '0, wr_blank = '0;
    logic [7:0]   a_seg, b_seg;
    logic [3:0]   a_dig, b_dig;
    logic         a_pend, b_pend, a_tick, b_tick;

    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_SUPPRESS(0),
                   .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .seg(a_seg), .dig(a_dig), .upd_pending(a_pend), .frame_tick(a_tick));
    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_SUPPRESS(1),
                   .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .seg(b_seg), .dig(b_dig), .upd_pending(b_pend), .frame_tick(b_tick));

    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // {digit enable, lit segments} for digit k of a displayed value
    function automatic logic [8:0] shown(int k, logic [15:0] d, logic [3:0] dp, logic [3:0] bl, bit lz);
        bit lead;
        if (bl[k]) return 9'h000;
        lead = lz && (k > 0);
        for (int j = k; j < N; j++)
            if (((d >> (4*j)) & 16'hF) != 0 && !bl[j]) lead = 0;
        if (lead) return dp[k] ? 9'h180 : 9'h000;
        return {1'b1, dp[k], segtab[(d >> (4*k)) & 16'hF]};
    endfunction

    // behavioural model: time since reset determines slot and position directly
    int          t;
    logic [15:0] md, pd;
    logic [3:0]  mdp, mbl, pdp, pbl;
    bit          pf;
    logic [7:0]  e_seg [2];
    logic [3:0]  e_dig [2];
    logic        e_tick, e_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0; md = 0; mdp = 0; mbl = 4'hF; pd = 0; pdp = 0; pbl = 4'hF; pf = 0;
            for (int i = 0; i < 2; i++) begin e_seg[i] = 8'hFF; e_dig[i] = 4'hF; end
            e_tick = 0; e_pend = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [8:0] r;
                r = shown((t / SD) % N, md, mdp, mbl, i == 1);
                if ((t % SD) < BL) begin e_seg[i] = 8'hFF; e_dig[i] = 4'hF; end
                else begin
                    e_seg[i] = ~r[7:0];
                    e_dig[i] = r[8] ? ~(4'b0001 << ((t / SD) % N)) : 4'hF;
                end
            end
            if ((t % FR) == FR-1) begin
                if (wr_en) begin md = wr_data; mdp = wr_dp; mbl = wr_blank; end
                else if (pf) begin md = pd; mdp = pdp; mbl = pbl; end
                pf = 0;
            end else if (wr_en) begin
                pd = wr_data; pdp = wr_dp; pbl = wr_blank; pf = 1;
            end
            t++;
            e_tick = (t % FR) == FR-1;
            e_pend = pf;
        end
    end

    int ncyc = 0;
    always @(posedge clk) ncyc++;

    // hand-computed expectations pinned to absolute cycle numbers
    int         pin_n = 0;
    int         pin_at [64];
    bit         pin_b [64];
    logic [7:0] pin_seg [64];
    logic [3:0] pin_dig [64];
    int         to_cnt = 0;

    task automatic add_pin(int at, bit b, logic [7:0] s, logic [3:0] dg);
        pin_at[pin_n] = at; pin_b[pin_n] = b; pin_seg[pin_n] = s; pin_dig[pin_n] = dg;
        pin_n++;
    endtask

    int cmp_cnt = 0, err_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t cyc %0d: got %h expected %h", nm, $time, ncyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("a_seg", 32'(a_seg), 32'(e_seg[0]));
        chk("a_dig", 32'(a_dig), 32'(e_dig[0]));
        chk("b_seg", 32'(b_seg), 32'(e_seg[1]));
        chk("b_dig", 32'(b_dig), 32'(e_dig[1]));
        chk("a_tick", 32'(a_tick), 32'(e_tick));
        chk("b_tick", 32'(b_tick), 32'(e_tick));
        chk("a_pend", 32'(a_pend), 32'(e_pend));
        chk("b_pend", 32'(b_pend), 32'(e_pend));
        chk("tick_timeout", 32'(to_cnt), 32'd0);
        for (int i = 0; i < pin_n; i++)
            if (pin_at[i] == ncyc) begin
                chk(pin_b[i] ? "pin_b_seg" : "pin_a_seg", 32'(pin_b[i] ? b_seg : a_seg), 32'(pin_seg[i]));
                chk(pin_b[i] ? "pin_b_dig" : "pin_a_dig", 32'(pin_b[i] ? b_dig : a_dig), 32'(pin_dig[i]));
            end
    end

    task automatic write(logic [15:0] d, logic [3:0] dp, logic [3:0] bl);
        wr_data = d; wr_dp = dp; wr_blank = bl; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // returns at the negedge of a frame-wrap cycle, with k = cycle number there
    task automatic wait_tick(output int k);
        bit seen = 0;
        for (int i = 0; i < 2*FR && !seen; i++) begin
            @(negedge clk);
            seen = (a_tick === 1'b1);
        end
        if (!seen) to_cnt++;
        k = ncyc;
    endtask

    initial begin
        int k;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        add_pin(ncyc + 1, 0, 8'hFF, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        wait_tick(k);
        repeat (5) @(negedge clk);
        write(16'h12AF, 4'b0010, 4'b0000);
        wait_tick(k);
        add_pin(k + 2,  0, 8'hFF, 4'hF);
        add_pin(k + 4,  0, ~8'h71, 4'b1110);
        add_pin(k + 10, 0, 8'hFF, 4'hF);
        add_pin(k + 12, 0, ~8'hF7, 4'b1101);
        add_pin(k + 20, 0, ~8'h5B, 4'b1011);
        add_pin(k + 28, 0, ~8'h06, 4'b0111);
        repeat (40) @(negedge clk);

        wait_tick(k);
        repeat (3) @(negedge clk);
        write(16'h1111, 4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
        write(16'h2222, 4'b0000, 4'b0000);
        wait_tick(k);
        add_pin(k + 4, 0, ~8'h5B, 4'b1110);
        repeat (40) @(negedge clk);

        wait_tick(k);
        write(16'h0005, 4'b0000, 4'b0000);
        add_pin(k + 4, 0, ~8'h6D, 4'b1110);
        add_pin(k + 4, 1, ~8'h6D, 4'b1110);
        add_pin(k + 12, 1, 8'hFF, 4'hF);
        repeat (40) @(negedge clk);

        wait_tick(k);
        repeat (5) @(negedge clk);
        write(16'h0040, 4'b0000, 4'b0000);
        wait_tick(k);
        add_pin(k + 4,  1, ~8'h3F, 4'b1110);
        add_pin(k + 12, 1, ~8'h66, 4'b1101);
        add_pin(k + 20, 1, 8'hFF, 4'hF);
        add_pin(k + 28, 1, 8'hFF, 4'hF);
        repeat (5) @(negedge clk);
        write(16'h0000, 4'b0000, 4'b0000);
        wait_tick(k);
        add_pin(k + 4,  1, ~8'h3F, 4'b1110);
        add_pin(k + 12, 1, 8'hFF, 4'hF);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            write(16'($urandom), 4'($urandom), 4'($urandom & $urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        wait_tick(k);
        repeat (5) @(negedge clk);
        write(16'hFFFF, 4'b0000, 4'b0000);
        wait_tick(k);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        add_pin(ncyc, 0, 8'hFF, 4'hF);
        #10 rst = 1'b0;
        repeat (70) @(negedge clk);
        write(16'h9876, 4'b1001, 4'b0000);
        repeat (80) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed driver for a parametrised bank of common-anode/cathode 7-segment digits with decimal points. It holds a shadow copy of the displayed value and commits host updates only at frame boundaries, so the display never tears. It cycles the digit enables at a programmable rate and inserts a blanking guard at each digit change to suppress ghosting. It sits between a CPU-visible register (picorv32 GPIO/MMIO) and the board LED pins, replacing per-digit static decode.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
- BLANK_CYCLES, 16, cycles at the start of each slot with all outputs inactive (0 <= BLANK_CYCLES < SCAN_DIV)
- LZ_SUPPRESS, 0, 1 = blank leading zero digits (digit 0 is never suppressed)
- SEG_ACTIVE_LOW, 1, polarity of seg outputs
- DIG_ACTIVE_LOW, 1, polarity of dig outputs

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  single-cycle update strobe
- wr_data  in  4*NUM_DIGITS  hex nibbles; digit k = wr_data[4k+3:4k], digit 0 least significant
- wr_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- wr_blank  in  NUM_DIGITS  force digit dark, 1 = blank
- seg  out  8  {DP,G,F,E,D,C,B,A}, registered
- dig  out  NUM_DIGITS  one-hot digit enable, registered
- upd_pending  out  1  update accepted but not yet displayed
- frame_tick  out  1  one-cycle pulse at each frame wrap

## Operation
- Divider div_cnt counts 0..SCAN_DIV-1, wraps to 0; digit index idx advances on wrap, 0..NUM_DIGITS-1, then back to 0.
- Frame wrap = cycle where div_cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1; frame_tick is high that cycle only.
- wr_en loads pending registers (data, dp, blank) and sets upd_pending. A later wr_en before commit overwrites (latest wins).
- Commit on the frame-wrap edge: if upd_pending or wr_en, display regs <= pending (or the wr_en data directly when wr_en coincides), and upd_pending clears. wr_en on any other cycle never alters display regs.
- Decode (hex 0-F, standard segments, logic-1 = lit before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; DP = bit 7.
- Digit k is dark (no segments, no DP, dig[k] inactive) when blank[k]=1, or when LZ_SUPPRESS=1, k>0, and nibbles k..NUM_DIGITS-1 are all 0 and not forced visible. A blanked digit above a nonzero one does not stop suppression. A DP on a zero-suppressed digit is still lit.
- Guard: while div_cnt < BLANK_CYCLES, all dig inactive and seg all unlit.
- Otherwise dig has exactly the idx bit active and seg = decode of display digit idx; a dark digit drives the idx bit inactive and seg unlit.
- Polarity parameters invert the final registered outputs only.

## Timing
- Reset (async assert, sync-release by system): div_cnt=0, idx=0, display and pending regs = all digits blanked, dp=0, upd_pending=0, frame_tick=0, dig all inactive, seg all unlit (polarity-applied: 8'hFF and all-ones for defaults).
- seg/dig lag (div_cnt, idx, display) by exactly one clock.
- upd_pending rises the cycle after wr_en. The new value appears on seg one clock after commit, at the first non-guard cycle of digit 0 of the next frame.
- Worst-case update latency: NUM_DIGITS*SCAN_DIV + BLANK_CYCLES + 1 cycles.
- Reset mid-frame discards pending and display; scan restarts at digit 0.
- NUM_DIGITS=1: every divider wrap is a frame wrap; dig constant except during guard.
- BLANK_CYCLES=0: no guard; digit change is a single-edge switch.

## Test plan
Use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low defaults.
- Reset release, no writes -> dig=4'hF and seg=8'hFF for 100 cycles; frame_tick every 32 cycles; upd_pending=0.
- wr_data=16'h12AF, wr_dp=4'b0010, wr_blank=0 mid-frame -> upd_pending=1 until next frame wrap. Next frame, slot 0: dig=4'b1110, seg=~8'h71. Slot 1: dig=4'b1101, seg=~(8'h77|8'h80). Slot 2 shows ~8'h5B, slot 3 shows ~8'h06. Each slot has exactly 2 guard cycles (dig=4'hF) then 6 active cycles.
- Two writes, 16'h1111 then 16'h2222, in the same frame -> only 2222 is ever displayed; 1111 never appears.
- wr_en exactly on frame-wrap cycle with 16'h0005 -> committed same edge; upd_pending stays 0; digit 0 shows ~8'h6D in the following frame.
- LZ_SUPPRESS=1, wr_data=16'h0040 -> digits 3 and 2 dark (dig bit never active), digit 1 = ~8'h66, digit 0 = ~8'h3F. With 16'h0000, only digit 0 is lit, showing 0.
- Assert rst for 1 cycle mid-slot of digit 2 with display 16'hFFFF -> outputs go inactive immediately (async). After release, scan restarts at digit 0 and all digits stay dark until a new write is committed.
